// File: rtl/ece2300_stream_sink_checker.sv
// Self-checking stream sink: compares incoming val/rdy messages against a
// preloaded expected table and reports a hardware pass/fail verdict.
module ece2300_stream_sink_checker #(
  parameter  int p_nbits    = 8,
  parameter  int p_nmsgs    = 16,
  parameter  int p_timeout  = 10000,
  parameter  int p_rand_rdy = 0,
  localparam int AW         = $clog2(p_nmsgs)
) (
  input  logic               i_clk,
  input  logic               i_reset,          // active-low, async assert
  input  logic               i_load_en,
  input  logic [AW-1:0]      i_load_addr,
  input  logic [p_nbits-1:0] i_load_data,
  input  logic [AW:0]        i_num_msgs,
  input  logic               i_start,
  input  logic               i_in_val,
  output logic               o_in_rdy,
  input  logic [p_nbits-1:0] i_in_msg,
  output logic               o_done,
  output logic               o_passed,
  output logic               o_timed_out,
  output logic [AW:0]        o_err_count,
  output logic [AW-1:0]      o_first_err_idx,
  output logic [31:0]        o_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TOUT} state_t;

  localparam logic [31:0] LP_TO_LAST = 32'(p_timeout - 1);
  localparam logic        LP_RAND    = (p_rand_rdy != 0);

  state_t              r_state;
  logic [p_nbits-1:0]  r_tbl [p_nmsgs];
  logic [AW:0]         r_idx;
  logic [AW:0]         r_num;
  logic [15:0]         r_lfsr;
  logic                r_rdy;
  logic                r_done;
  logic                r_passed;
  logic                r_tout;
  logic [AW:0]         r_err;
  logic [AW-1:0]       r_first;
  logic [31:0]         r_cyc;

  logic                w_xfer;
  logic                w_mis;
  logic                w_last;
  logic [15:0]         w_lfsr_nx;

  // Transfer/compare decode; the compare is combinational against the table.
  always_comb begin
    w_xfer    = i_in_val && r_rdy;
    w_mis     = (i_in_msg != r_tbl[r_idx[AW-1:0]]);
    w_last    = (r_idx == (r_num - 1'b1));
    w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Expected-message table: written only while idle, never reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_load_en)
      r_tbl[i_load_addr] <= i_load_data;
  end

  // Run-control FSM with registered outputs. r_rdy is always loaded with the
  // value (next_state==RUN && next_lfsr[0]) so it never looks at in_val.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_num    <= '0;
      r_lfsr   <= 16'hbeef;
      r_rdy    <= 1'b0;
      r_done   <= 1'b0;
      r_passed <= 1'b0;
      r_tout   <= 1'b0;
      r_err    <= '0;
      r_first  <= '0;
      r_cyc    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TOUT: begin
          if (i_start) begin
            r_idx   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_cyc   <= '0;
            r_num   <= i_num_msgs;
            r_tout  <= 1'b0;
            if (i_num_msgs == '0) begin
              // Nothing to check: trivially passed.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_passed <= 1'b1;
              r_rdy    <= 1'b0;
            end else begin
              r_state  <= S_RUN;
              r_done   <= 1'b0;
              r_passed <= 1'b0;
              r_rdy    <= LP_RAND ? r_lfsr[0] : 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cyc  <= r_cyc + 32'd1;
          r_lfsr <= w_lfsr_nx;
          if (w_xfer) begin
            if (w_mis) begin
              if (r_err == '0) r_first <= r_idx[AW-1:0];
              if (r_err != '1) r_err   <= r_err + 1'b1;
            end
            r_idx <= r_idx + 1'b1;
          end
          // Final transfer takes priority over a coincident timeout.
          if (w_xfer && w_last) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_passed <= (r_err == '0) && !w_mis;
            r_rdy    <= 1'b0;
          end else if (r_cyc == LP_TO_LAST) begin
            r_state  <= S_TOUT;
            r_done   <= 1'b1;
            r_passed <= 1'b0;
            r_tout   <= 1'b1;
            r_rdy    <= 1'b0;
          end else begin
            r_rdy    <= LP_RAND ? w_lfsr_nx[0] : 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_rdy        = r_rdy;
  assign o_done          = r_done;
  assign o_passed        = r_passed;
  assign o_timed_out     = r_tout;
  assign o_err_count     = r_err;
  assign o_first_err_idx = r_first;
  assign o_cycles        = r_cyc;

endmodule
